// File: rtl/btn_frame_sync_if.sv
// Button/video handshake bundle between the board-side driver and btn_frame_sync.
// The master drives raw buttons and vsync; the slave returns the frame-aligned mode bus.
interface btn_frame_sync_if;
    logic [3:0] i_btn;
    logic       i_vid_vsync;
    logic [3:0] o_btn;
    logic       o_btn_pending;
    logic       o_btn_update;

    modport master (
        output i_btn,
        output i_vid_vsync,
        input  o_btn,
        input  o_btn_pending,
        input  o_btn_update
    );

    modport slave (
        input  i_btn,
        input  i_vid_vsync,
        output o_btn,
        output o_btn_pending,
        output o_btn_update
    );
endinterface

// File: rtl/btn_frame_sync.sv
// Synchronises and debounces four board buttons, then applies the result only at a vsync leading edge.
// Define BTN_ONEHOT_EN to treat multi-bit debounced values as illegal (never armed, never applied).
module btn_frame_sync #(
    parameter int   DEBOUNCE_CYCLES = 1485000,
    parameter int   CNT_W           = 21,
    parameter logic VSYNC_POL       = 1'b1
) (
    input logic             clk,
    input logic             n_rst,
    btn_frame_sync_if.slave bus
);

`ifdef BTN_ONEHOT_EN
    localparam bit OneHotEn = 1'b1;
`else
    localparam bit OneHotEn = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE,
        ARMED
    } state_t;

    logic [3:0]       syncOne_q;
    logic [3:0]       syncTwo_q;
    logic [3:0]       deb_q;
    logic [3:0]       deb_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic             vsyncDly_q;
    logic             frameEdge;
    logic [3:0]       btn_q;
    logic [3:0]       nextBtn;
    logic             pending_q;
    logic             update_q;
    logic             armNext;
    state_t           state_q;

    function automatic logic isLegal(input logic [3:0] v);
        return !OneHotEn || ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Each bit must disagree with its debounced value for DEBOUNCE_CYCLES consecutive cycles to flip.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (syncTwo_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    deb_d[i] = syncTwo_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            syncOne_q  <= '0;
            syncTwo_q  <= '0;
            deb_q      <= '0;
            vsyncDly_q <= ~VSYNC_POL;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            syncOne_q  <= bus.i_btn;
            syncTwo_q  <= syncOne_q;
            deb_q      <= deb_d;
            vsyncDly_q <= bus.i_vid_vsync;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign frameEdge = (bus.i_vid_vsync == VSYNC_POL) && (vsyncDly_q != VSYNC_POL);

    // Pending is computed against next-cycle values so it stays aligned with deb; an edge samples the pre-update deb.
    assign nextBtn = ((state_q == ARMED) && frameEdge) ? deb_q : btn_q;
    assign armNext = isLegal(deb_d) && (deb_d != nextBtn);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            btn_q     <= '0;
            pending_q <= 1'b0;
            update_q  <= 1'b0;
        end else begin
            update_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (armNext) begin
                        state_q   <= ARMED;
                        pending_q <= 1'b1;
                    end
                end
                ARMED: begin
                    if (frameEdge) begin
                        btn_q    <= deb_q;
                        update_q <= 1'b1;
                    end
                    if (!armNext) begin
                        state_q   <= IDLE;
                        pending_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    pending_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_btn         = btn_q;
    assign bus.o_btn_pending = pending_q;
    assign bus.o_btn_update  = update_q;

endmodule

// File: tb/tb_btn_frame_sync.sv
// Scoreboard bench for btn_frame_sync: expected o_btn values are queued at stimulus time
// and popped by a monitor on every o_btn_update pulse; vsync pulses 4 cycles every 200.
module tb_btn_frame_sync;

`ifdef BTN_ONEHOT_EN
    localparam bit OneHot = 1'b1;
`else
    localparam bit OneHot = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       n_rst;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [3:0] expQ[$];
    logic [3:0] sbExp;
    logic       sawPend;

    btn_frame_sync_if busIf ();

    btn_frame_sync #(
        .DEBOUNCE_CYCLES(8),
        .CNT_W          (4),
        .VSYNC_POL      (1'b1)
    ) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (busIf.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (cyc %0d)", name, actual, expected, cyc);
        end
    endtask

    // One pixel clock: vsync is active for phases 100..103 of every 200-cycle frame.
    task automatic tick();
        busIf.i_vid_vsync = ((cyc % 200) >= 100) && ((cyc % 200) < 104);
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [3:0] b, input int n);
        busIf.i_btn = b;
        repeat (n) tick();
    endtask

    task automatic runTo(input int target);
        while (cyc < target) tick();
    endtask

    // Every update pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (busIf.o_btn_update === 1'b1) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_update: got update with o_btn=%h, expected no update (cyc %0d)", busIf.o_btn, cyc);
            end else begin
                sbExp = expQ.pop_front();
                if (busIf.o_btn !== sbExp) begin
                    errors++;
                    $display("[TB] FAIL sb_value: got o_btn=%h, expected %h (cyc %0d)", busIf.o_btn, sbExp, cyc);
                end
            end
        end
    end

    initial begin
        n_rst             = 1'b1;
        busIf.i_btn       = 4'hF;
        busIf.i_vid_vsync = 1'b0;
        #2 n_rst = 1'b0;
        #1;
        checkOutput("rst_btn", busIf.o_btn, 4'h0);
        checkOutput("rst_pending", {3'b000, busIf.o_btn_pending}, 4'h0);
        checkOutput("rst_update", {3'b000, busIf.o_btn_update}, 4'h0);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;

        // Single press held across the cycle-100 frame edge.
        applyStimulus(4'h2, 9);
        checkOutput("press_pend_early", {3'b000, busIf.o_btn_pending}, 4'h0);
        tick();
        checkOutput("press_pend_set", {3'b000, busIf.o_btn_pending}, 4'h1);
        expQ.push_back(4'h2);
        runTo(100);
        checkOutput("press_btn_before_edge", busIf.o_btn, 4'h0);
        tick();
        checkOutput("press_btn_at_edge", busIf.o_btn, 4'h2);
        checkOutput("press_update", {3'b000, busIf.o_btn_update}, 4'h1);
        checkOutput("press_pend_clear", {3'b000, busIf.o_btn_pending}, 4'h0);

        // Release, applied at the cycle-300 edge.
        runTo(150);
        applyStimulus(4'h0, 10);
        checkOutput("release_pend", {3'b000, busIf.o_btn_pending}, 4'h1);
        expQ.push_back(4'h0);
        runTo(301);
        checkOutput("release_btn", busIf.o_btn, 4'h0);
        checkOutput("release_pend_clear", {3'b000, busIf.o_btn_pending}, 4'h0);

        // Five-cycle glitch must never reach deb.
        runTo(310);
        applyStimulus(4'h1, 5);
        busIf.i_btn = 4'h0;
        sawPend = 1'b0;
        while (cyc < 701) begin
            tick();
            sawPend |= busIf.o_btn_pending;
        end
        checkOutput("glitch_no_pending", {3'b000, sawPend}, 4'h0);
        checkOutput("glitch_btn", busIf.o_btn, 4'h0);

        // Bounce: toggle every 3 cycles for 30 cycles, then hold.
        runTo(710);
        for (int k = 0; k < 10; k++) begin
            applyStimulus((k % 2 == 0) ? 4'h1 : 4'h0, 3);
        end
        applyStimulus(4'h1, 9);
        checkOutput("bounce_pend_early", {3'b000, busIf.o_btn_pending}, 4'h0);
        tick();
        checkOutput("bounce_pend_set", {3'b000, busIf.o_btn_pending}, 4'h1);
        expQ.push_back(4'h1);
        runTo(901);
        checkOutput("bounce_btn", busIf.o_btn, 4'h1);

        // Collision: deb becomes 4 on the cycle-1100 frame edge.
        runTo(1091);
        applyStimulus(4'h4, 9);
        checkOutput("coll_pend_pre", {3'b000, busIf.o_btn_pending}, 4'h0);
        tick();
        checkOutput("coll_btn_hold", busIf.o_btn, 4'h1);
        checkOutput("coll_no_update", {3'b000, busIf.o_btn_update}, 4'h0);
        checkOutput("coll_pend_set", {3'b000, busIf.o_btn_pending}, 4'h1);
        expQ.push_back(4'h4);
        runTo(1301);
        checkOutput("coll_btn_next", busIf.o_btn, 4'h4);

        // Multi-bit value: passes through, or is ignored when one-hot checking is enabled.
        runTo(1310);
        applyStimulus(4'h6, 10);
        checkOutput("illegal_pend", {3'b000, busIf.o_btn_pending}, OneHot ? 4'h0 : 4'h1);
        if (!OneHot) expQ.push_back(4'h6);
        runTo(1501);
        checkOutput("illegal_btn", busIf.o_btn, OneHot ? 4'h4 : 4'h6);

        // Reset mid-operation with all buttons held.
        runTo(1510);
        applyStimulus(4'hF, 5);
        #2 n_rst = 1'b0;
        #1;
        checkOutput("midrst_btn", busIf.o_btn, 4'h0);
        checkOutput("midrst_pending", {3'b000, busIf.o_btn_pending}, 4'h0);
        checkOutput("midrst_update", {3'b000, busIf.o_btn_update}, 4'h0);
        repeat (3) tick();
        n_rst = 1'b1;
        applyStimulus(4'hF, 9);
        checkOutput("midrst_pend_early", {3'b000, busIf.o_btn_pending}, 4'h0);
        tick();
        checkOutput("midrst_pend_set", {3'b000, busIf.o_btn_pending}, OneHot ? 4'h0 : 4'h1);
        if (!OneHot) expQ.push_back(4'hF);
        runTo(1701);
        checkOutput("midrst_btn_edge", busIf.o_btn, OneHot ? 4'h0 : 4'hF);

        repeat (4) tick();
        checkOutput("sb_drain", 4'(expQ.size()), 4'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/btn_frame_sync.md
Name: btn_frame_sync

Overview:
- Upstream control stage for the pixel filter blocks.
- Takes the raw, asynchronous board buttons and synchronises and debounces each one.
- Presents the resulting 4-bit mode bus to the filters as `btn`.
- Changes to that bus take effect only at the start of a vertical sync pulse, so no filter mode ever switches mid-frame; a frame is never partly inverted.

Parameters:
- DEBOUNCE_CYCLES, 1485000, number of consecutive cycles a synchronised input must differ from its debounced value before that value flips (20 ms at 74.25 MHz).
- CNT_W, 21, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- VSYNC_POL, 1, active level of i_vid_vsync (1 = active-high pulse, 0 = active-low pulse).

Ports:
- clk  input  1  pixel clock; all logic on the rising edge.
- n_rst  input  1  asynchronous, active-low reset.
- i_btn  input  4  raw push buttons, asynchronous to clk.
- i_vid_vsync  input  1  vertical sync, same timing as the video stream entering the filters.
- o_btn  output  4  frame-aligned, debounced button bus; drives the filters' btn input.
- o_btn_pending  output  1  high while the debounced value differs from o_btn.
- o_btn_update  output  1  one-cycle pulse on the cycle o_btn takes a new value.

Behaviour:
- Reset: all of the following clear to 0 immediately on n_rst low, independent of clk:
  - synchroniser flops, debounce counters, debounced register (deb), pending register
  - vsync delay flop; its reset value is the inactive level, ~VSYNC_POL
  - o_btn, o_btn_pending, o_btn_update
- Reset mid-operation discards any press in progress. After release, a held button needs the full 2 + DEBOUNCE_CYCLES cycles again.
- Synchroniser: two flops per bit (s1, s2). s2 reaches the debouncer 2 cycles after i_btn is sampled.
- Debounce, per bit, independent of the other bits:
  - If s2 == deb[i], the counter is set to 0.
  - Otherwise the counter increments.
  - When s2 != deb[i] and the counter == DEBOUNCE_CYCLES-1, deb[i] <= s2 and the counter <= 0.
  - Any return of s2 to deb[i] before that point restarts the count, so pulses shorter than DEBOUNCE_CYCLES cycles never pass.
  - The counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- Frame alignment FSM, two states:
  - IDLE: deb == o_btn. o_btn_pending = 0.
  - ARMED: deb != o_btn. o_btn_pending = 1.
  - IDLE -> ARMED when deb changes.
  - ARMED -> IDLE on a frame edge: o_btn <= deb and o_btn_update = 1 for that cycle. If deb has returned to the o_btn value before the edge, the transition is to IDLE with no update and no pulse.
  - Repeated deb changes within one frame: only the value present at the edge is applied.
- Frame edge definition:
  - frame_edge = (i_vid_vsync == VSYNC_POL) && (vsync_d != VSYNC_POL), where vsync_d is i_vid_vsync registered once.
  - o_btn updates on the clock edge at which vsync is first sampled active.
- Simultaneous events: a deb update and a frame edge in the same cycle. o_btn samples the pre-update deb value; the new value is applied at the following frame edge.
- Vsync stuck: if vsync is stuck active or absent, o_btn holds its value indefinitely and o_btn_pending stays asserted.
- Outputs: o_btn and o_btn_update are registered. o_btn_pending is registered, aligned with deb.

Optional Feature:
- Macro: BTN_ONEHOT_EN.
- Defined: a deb value with more than one bit set is illegal.
  - The FSM treats it as equal to o_btn: no ARMED entry, no update.
  - o_btn therefore only ever holds 0 or a one-hot value.
  - o_btn_pending stays 0 while deb is illegal.
- Undefined: every 4-bit value passes through unchanged.

Test Plan (DEBOUNCE_CYCLES=8, CNT_W=4, VSYNC_POL=1, vsync pulses of 4 cycles every 200 cycles):
- Reset check: assert n_rst low mid-clock with i_btn=4'hF -> o_btn=0, o_btn_pending=0 and o_btn_update=0 immediately; after release, o_btn stays 0 until 2+8 cycles of stable input plus the next frame edge.
- Single press: i_btn=4'b0010 held 50 cycles from cycle 0; frame edge at cycle 100 -> o_btn_pending rises about cycle 10; o_btn=4'h2 and a one-cycle o_btn_update at the cycle-100 edge; o_btn_pending falls.
- Glitch rejection: i_btn=4'b0001 for 5 cycles, then 0 -> deb never changes; o_btn stays 0 across the next two frames; no update pulse.
- Bounce: i_btn[0] toggles every 3 cycles for 30 cycles, then is held 1 -> deb[0] sets exactly 8 cycles after the last toggle reaches s2; o_btn=4'h1 at the next frame edge.
- Collision: arrange for deb to become 4'h4 on the same cycle as a frame edge -> o_btn is unchanged at that edge; o_btn=4'h4 at the following edge, 200 cycles later.
- Illegal value: i_btn=4'b0110 held -> with BTN_ONEHOT_EN defined, o_btn stays 0 and o_btn_pending stays 0; without the macro, o_btn=4'h6 at the next frame edge.
